// File: rtl/rx_pkg.sv
// Shared types and default sizing for the UART receive sequencer.
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECEIVE,
    STOP_CHK,
    LOAD
  } rx_state_t;

  localparam int unsigned CLKS_PER_BIT = 10;
  localparam int unsigned NUM_BITS     = 9;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer and shifted-bit counter; strobe marks the last cycle of each bit period.
module rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = rx_pkg::CLKS_PER_BIT,
  parameter int unsigned NUM_BITS     = rx_pkg::NUM_BITS,
  localparam int unsigned TW = $clog2(CLKS_PER_BIT),
  localparam int unsigned CW = $clog2(NUM_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic          strobe,
  output logic          half_bit,
  output logic [CW-1:0] bit_count
);

  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);

  logic [TW-1:0] timer;

  assign strobe   = enable && (timer == LAST);
  // Half-period tick lets the start-bit check reuse this timer.
  assign half_bit = enable && (timer == HALF);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      timer     <= '0;
      bit_count <= '0;
    end else if (enable) begin
      timer <= strobe ? '0 : timer + 1'b1;
      if (strobe) bit_count <= bit_count + 1'b1;
    end
  end

endmodule

// File: rtl/rx_sequencer.sv
// UART receive sequencer: synchronizes the line, validates start/stop bits and
// sequences shift strobes and the buffer load for a downstream shift register.
module rx_sequencer #(
  parameter int unsigned CLKS_PER_BIT = rx_pkg::CLKS_PER_BIT,
  parameter int unsigned NUM_BITS     = rx_pkg::NUM_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic stop_bit,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
);

  import rx_pkg::*;

  localparam int unsigned   CW       = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

  rx_state_t     state;
  rx_state_t     next_state;
  logic          sync_ff;
  logic          sync_in;
  logic          prev_in;
  logic          start_edge;
  logic          timer_clear;
  logic          timer_en;
  logic          strobe;
  logic          half_bit;
  logic          fe_set;
  logic          fe_clr;
  logic [CW-1:0] bit_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= 1'b0;
      sync_in <= 1'b0;
      prev_in <= 1'b0;
    end else begin
      sync_ff <= serial_in;
      sync_in <= sync_ff;
      prev_in <= sync_in;
    end
  end

  // Flops reset low, so a line held low from reset never looks like a falling edge.
  assign start_edge = prev_in && !sync_in;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .NUM_BITS    (NUM_BITS)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .enable   (timer_en),
    .strobe   (strobe),
    .half_bit (half_bit),
    .bit_count(bit_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      framing_error <= 1'b0;
    end else begin
      state <= next_state;
      if (fe_set)      framing_error <= 1'b1;
      else if (fe_clr) framing_error <= 1'b0;
    end
  end

  always_comb begin
    next_state  = state;
    timer_clear = 1'b0;
    fe_set      = 1'b0;
    fe_clr      = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          next_state  = START_CHK;
          timer_clear = 1'b1;
        end
      end
      START_CHK: begin
        if (half_bit) begin
          timer_clear = 1'b1;
          if (!sync_in) begin
            next_state = RECEIVE;
            fe_clr     = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      RECEIVE: begin
        if (strobe && (bit_count == LAST_BIT)) next_state = STOP_CHK;
      end
      STOP_CHK: begin
        if (stop_bit) begin
          next_state = LOAD;
        end else begin
          next_state = IDLE;
          fe_set     = 1'b1;
        end
      end
      LOAD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    timer_en     = (state == START_CHK) || (state == RECEIVE);
    shift_strobe = (state == RECEIVE) && strobe;
    load_buffer  = (state == LOAD);
    rx_busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_rx_sequencer.sv
// Directed bench for rx_sequencer with a model 9-bit downstream shift register.
module tb_rx_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic stop_bit;
  logic shift_strobe;
  logic load_buffer;
  logic framing_error;
  logic rx_busy;

  always #5 clk = ~clk;

  rx_sequencer #(
    .CLKS_PER_BIT(10),
    .NUM_BITS    (9)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .stop_bit     (stop_bit),
    .shift_strobe (shift_strobe),
    .load_buffer  (load_buffer),
    .framing_error(framing_error),
    .rx_busy      (rx_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_load;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[5];

  int passed = 0;
  int total  = 0;

  logic [8:0] sreg;
  logic       strobe_seen = 1'b0;
  int         cyc = 0;
  int         strobe_cnt = 0;
  int         load_cnt = 0;
  int         busy_cnt = 0;
  int         excl_bad = 0;
  int         load_t = 0;
  int         strobe_t[0:255];

  assign stop_bit = sreg[8];

  always @(posedge clk) begin
    if (rst)              sreg <= '0;
    else if (strobe_seen) sreg <= {serial_in, sreg[8:1]};
  end

  always @(negedge clk) begin
    cyc         <= cyc + 1;
    strobe_seen <= shift_strobe;
    if (shift_strobe) begin
      strobe_t[strobe_cnt[7:0]] <= cyc;
      strobe_cnt <= strobe_cnt + 1;
    end
    if (load_buffer) begin
      load_cnt <= load_cnt + 1;
      load_t   <= cyc;
    end
    if (rx_busy) busy_cnt <= busy_cnt + 1;
    if ((shift_strobe && load_buffer) || (!rx_busy && (shift_strobe || load_buffer)))
      excl_bad <= excl_bad + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic bit_out(input logic v);
    serial_in = v;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic stop, input int exp_load,
                           input logic exp_fe);
    int base_s;
    int base_l;
    int gap_ok;
    base_s = strobe_cnt;
    base_l = load_cnt;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(stop);
    idle(20);
    check("strobe_count", strobe_cnt - base_s, 9);
    gap_ok = (strobe_cnt - base_s >= 9) ? 1 : 0;
    for (int k = 1; k < 9; k++)
      if (strobe_t[base_s + k] - strobe_t[base_s + k - 1] != 10) gap_ok = 0;
    check("strobe_spacing", gap_ok, 1);
    check("load_count", load_cnt - base_l, exp_load);
    if (exp_load > 0) check("load_delay", load_t - strobe_t[base_s + 8], 2);
    check("data", int'(sreg[7:0]), int'(d));
    check("stop", int'(sreg[8]), int'(stop));
    check("framing_error", int'(framing_error), int'(exp_fe));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_shift_strobe"}, int'(shift_strobe), 0);
    check({tag, "_load_buffer"}, int'(load_buffer), 0);
    check({tag, "_framing_error"}, int'(framing_error), 0);
    check({tag, "_rx_busy"}, int'(rx_busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         base_s;
    int         base_l;
    int         base_b;
    int         seen_hi;
    int         back;
    logic [7:0] d55;

    vecs[0] = '{8'hA5, 1'b1, 1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1'b1};
    vecs[2] = '{8'h81, 1'b1, 1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 0, 1'b1};

    rst       = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(10);

    foreach (vecs[i]) run_frame(vecs[i].data, vecs[i].stop, vecs[i].exp_load, vecs[i].exp_fe);

    // Short low glitch on an idle line, framing_error still set from the last frame.
    base_s    = strobe_cnt;
    seen_hi   = 0;
    back      = -1;
    serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    serial_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rx_busy) seen_hi = 1;
      else if (seen_hi != 0 && back < 0) back = i + 3;
    end
    check("glitch_busy_seen", seen_hi, 1);
    check("glitch_recover", (back >= 0 && back <= 10) ? 1 : 0, 1);
    check("glitch_strobes", strobe_cnt - base_s, 0);
    check("glitch_framing_error", int'(framing_error), 1);
    idle(10);

    // Reset partway through a packet, then the line returns idle.
    d55    = 8'h55;
    base_s = strobe_cnt;
    base_l = load_cnt;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(d55[i]);
    check("midrst_pre_strobes", strobe_cnt - base_s, 4);
    serial_in = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs_zero("midrst");
    idle(120);
    check("midrst_post_strobes", strobe_cnt - base_s, 4);
    check("midrst_post_loads", load_cnt - base_l, 0);
    run_frame(8'h55, 1'b1, 1, 1'b0);

    // Line held low across reset release: no false start.
    rst       = 1'b1;
    serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    base_b = busy_cnt;
    base_s = strobe_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("lowhold_busy", busy_cnt - base_b, 0);
    check("lowhold_strobes", strobe_cnt - base_s, 0);
    idle(20);
    run_frame(8'h0F, 1'b1, 1, 1'b0);

    check("exclusivity", excl_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
